// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply-divide unit.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MADD    = 4'd7,
    MADDU   = 4'd8,
    MSUB    = 4'd9,
    MSUBU   = 4'd10
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_div(md_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // Ops that occupy the unit for several cycles; accumulate ops only exist when built in.
  function automatic logic is_multi(md_op_t op);
    case (op)
      MULT, MULTU, DIV, DIVU:   return 1'b1;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/readback bundle between the execute stage and the multiply-divide unit.
interface mdu_if #(parameter int WIDTH = 32);
  import mdu_pkg::*;

  logic             start;
  md_op_t           md_op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hilo_sel;
  logic [WIDTH-1:0] hilo_out;
  logic             busy;

  modport master (output start, md_op, rs_data, rt_data, hilo_sel,
                  input  hilo_out, busy);
  modport slave  (input  start, md_op, rs_data, rt_data, hilo_sel,
                  output hilo_out, busy);
endinterface

// File: rtl/mdu_calc.sv
// Combinational result datapath: product, quotient/remainder and (with MDU_MADD_EN)
// the 64-bit accumulate/subtract against the current HI/LO pair.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_by_zero
);

  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;

  // NOTE: every output and temporary gets a default at the top of the block so no
  // path through the case leaves a value held, which would infer a latch.
  always_comb begin
    is_signed   = (op == MULT) || (op == DIV) || (op == MADD) || (op == MSUB);
    a_neg       = is_signed & a[WIDTH-1];
    b_neg       = is_signed & b[WIDTH-1];
    a_ext       = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext       = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod        = a_ext * b_ext;

    // Divide on magnitudes so the most-negative / -1 case wraps back to itself.
    a_mag       = a_neg ? -a : a;
    b_mag       = b_neg ? -b : b;
    div_by_zero = is_div(op) && (b == '0);
    divisor     = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag       = a_mag / divisor;
    r_mag       = a_mag % divisor;

    res_hi      = hi;
    res_lo      = lo;
    case (op)
      MULT, MULTU: {res_hi, res_lo} = prod;
      DIV, DIVU: begin
        res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
        res_hi = a_neg ? -r_mag : r_mag;
      end
`ifdef MDU_MADD_EN
      MADD, MADDU: {res_hi, res_lo} = {hi, lo} + prod;
      MSUB, MSUBU: {res_hi, res_lo} = {hi, lo} - prod;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: IDLE/BUSY sequencer, latency counter, HI/LO and pending
// result registers, HI/LO read mux. MDU_MADD_EN adds the accumulate ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] hi, hi_next;
  logic [WIDTH-1:0] lo, lo_next;
  logic [WIDTH-1:0] pend_hi, pend_hi_next;
  logic [WIDTH-1:0] pend_lo, pend_lo_next;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             div_by_zero;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op         (bus.md_op),
    .a          (bus.rs_data),
    .b          (bus.rt_data),
    .hi         (hi),
    .lo         (lo),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .div_by_zero(div_by_zero)
  );

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    hi_next      = hi;
    lo_next      = lo;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_multi(bus.md_op)) begin
            state_next   = BUSY;
            cnt_next     = is_div(bus.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            // A zero divisor commits the current HI/LO, i.e. leaves them untouched.
            pend_hi_next = div_by_zero ? hi : res_hi;
            pend_lo_next = div_by_zero ? lo : res_lo;
          end else if (bus.md_op == MTHI) begin
            hi_next = bus.rs_data;
          end else if (bus.md_op == MTLO) begin
            lo_next = bus.rs_data;
          end
        end
      end
      BUSY: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          hi_next    = pend_hi;
          lo_next    = pend_lo;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

  // NOTE: the pending registers carry no reset; they are always loaded on the way
  // into BUSY and only read on the way out, so a stale value is never observed.
  always_ff @(posedge clk) begin
    pend_hi <= pend_hi_next;
    pend_lo <= pend_lo_next;
  end

  assign bus.busy     = (state == BUSY);
  assign bus.hilo_out = bus.hilo_sel ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed literal cases plus randomized traffic
// compared every cycle against a latency/arithmetic model. Honours MDU_MADD_EN.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int MULTC = 5;
  localparam int DIVC  = 10;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   armed    = 1'b0;

  always #5 clk = ~clk;

  mdu_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(MULTC), .DIV_CYCLES(DIVC)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Model: architectural HI/LO, the result waiting to land, and cycles left until it does.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    int          left;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t model_step(mstate_t s, logic rst_n, logic st, logic [3:0] op,
                                         logic [31:0] a, logic [31:0] b);
    mstate_t               n = s;
    longint                sa = $signed(a);
    longint                sb = $signed(b);
    longint unsigned       ua = a;
    longint unsigned       ub = b;
    logic [63:0]           p;
    longint                q;
    longint                r;
    if (!rst_n) return '0;
    if (s.left > 0) begin
      n.left = s.left - 1;
      if (n.left == 0) begin
        n.hi = s.p_hi;
        n.lo = s.p_lo;
      end
      return n;
    end
    if (!st) return n;
    case (op)
      4'd1: begin p = sa * sb; n.p_hi = p[63:32]; n.p_lo = p[31:0]; n.left = MULTC; end
      4'd2: begin p = ua * ub; n.p_hi = p[63:32]; n.p_lo = p[31:0]; n.left = MULTC; end
      4'd3, 4'd4: begin
        n.p_hi = s.hi;
        n.p_lo = s.lo;
        if (b != 0) begin
          q = (op == 4'd3) ? sa / sb : longint'(ua / ub);
          r = (op == 4'd3) ? sa % sb : longint'(ua % ub);
          n.p_lo = q[31:0];
          n.p_hi = r[31:0];
        end
        n.left = DIVC;
      end
      4'd5: n.hi = a;
      4'd6: n.lo = a;
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: begin
        p = (op == 4'd7 || op == 4'd9) ? sa * sb : ua * ub;
        p = (op <= 4'd8) ? {s.hi, s.lo} + p : {s.hi, s.lo} - p;
        n.p_hi = p[63:32];
        n.p_lo = p[31:0];
        n.left = MULTC;
      end
`endif
      default: ;
    endcase
    return n;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk)
    m <= model_step(m, reset_n, bus.start, bus.md_op, bus.rs_data, bus.rt_data);

  always @(negedge clk) begin
    if (armed) begin
      check("cmp_busy", {31'b0, bus.busy}, {31'b0, (m.left != 0)});
      check("cmp_hilo", bus.hilo_out, bus.hilo_sel ? m.hi : m.lo);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(md_op_t op, logic [31:0] a, logic [31:0] b);
    bus.start   = 1'b1;
    bus.md_op   = op;
    bus.rs_data = a;
    bus.rt_data = b;
    cyc();
    bus.start   = 1'b0;
    bus.md_op   = MD_NONE;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      cyc();
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.hilo_sel = 1'b1;
    #1 hi = bus.hilo_out;
    bus.hilo_sel = 1'b0;
    #1 lo = bus.hilo_out;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int          n;
    logic [31:0] hi, lo;

    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.md_op    = MD_NONE;
    bus.rs_data  = '0;
    bus.rt_data  = '0;
    bus.hilo_sel = 1'b0;
    cyc();
    armed = 1'b1;
    cyc();
    reset_n = 1'b1;

    read_hilo(hi, lo);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);

    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    check("mult_busy_cycles", n, MULTC);
    read_hilo(hi, lo);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(MULTU, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    read_hilo(hi, lo);
    check("multu_hi", hi, 32'h2);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    check("div_busy_cycles", n, DIVC);
    read_hilo(hi, lo);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    issue(DIVU, 32'd7, 32'd2);
    count_busy(n);
    read_hilo(hi, lo);
    check("divu_hi", hi, 32'h1);
    check("divu_lo", lo, 32'h3);

    issue(MTHI, 32'h1234, 32'h0);
    check("mthi_busy", {31'b0, bus.busy}, 32'h0);
    issue(MTLO, 32'h5678, 32'h0);
    check("mtlo_busy", {31'b0, bus.busy}, 32'h0);
    read_hilo(hi, lo);
    check("mt_hi", hi, 32'h1234);
    check("mt_lo", lo, 32'h5678);

    issue(MTHI, 32'hA, 32'h0);
    issue(MTLO, 32'hB, 32'h0);
    issue(DIV, 32'd100, 32'd0);
    count_busy(n);
    check("div0_busy_cycles", n, DIVC);
    read_hilo(hi, lo);
    check("div0_hi", hi, 32'hA);
    check("div0_lo", lo, 32'hB);

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    read_hilo(hi, lo);
    check("divovf_hi", hi, 32'h0);
    check("divovf_lo", lo, 32'h8000_0000);

    // Start ignored while busy, then reset aborts the multiply.
    issue(MTLO, 32'h77, 32'h0);
    issue(MULT, 32'd3, 32'd4);
    cyc();
    bus.start   = 1'b1;
    bus.md_op   = MTLO;
    bus.rs_data = 32'h9;
    cyc();
    bus.start   = 1'b0;
    bus.md_op   = MD_NONE;
    check("ignored_busy", {31'b0, bus.busy}, 32'h1);
    read_hilo(hi, lo);
    check("ignored_lo", lo, 32'h77);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    read_hilo(hi, lo);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);

    issue(MTHI, 32'h0, 32'h0);
    issue(MTLO, 32'hFFFF_FFFF, 32'h0);
    issue(MADDU, 32'd1, 32'd1);
    count_busy(n);
    read_hilo(hi, lo);
`ifdef MDU_MADD_EN
    check("maddu_busy_cycles", n, MULTC);
    check("maddu_hi", hi, 32'h1);
    check("maddu_lo", lo, 32'h0);
`else
    check("maddu_busy_cycles", n, 0);
    check("maddu_hi", hi, 32'h0);
    check("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 1500; i++) begin
      bus.hilo_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
      end else if ($urandom_range(0, 2) == 0) begin
        issue(md_op_t'(4'($urandom_range(0, 15))), rand_val(), rand_val());
      end else begin
        cyc();
      end
    end

    count_busy(n);
    check("final_idle", {31'b0, bus.busy}, 32'h0);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
